// File: rtl/phase_frequency_meter_if.sv
// Angle stream in, frequency readback out, for phase_frequency_meter.
// The master side is the generator/readback logic; the slave side is the meter.
interface phase_frequency_meter_if;
   logic [23:0] i_angle;
   logic        i_valid;
   logic [11:0] o_frequency;
   logic        o_freq_valid;
   logic        o_overflow;
   logic [23:0] o_step;

   modport master (
      output i_angle, i_valid,
      input  o_frequency, o_freq_valid, o_overflow, o_step
   );

   modport slave (
      input  i_angle, i_valid,
      output o_frequency, o_freq_valid, o_overflow, o_step
   );
endinterface

// File: rtl/phase_frequency_meter.sv
// phase_frequency_meter: recovers the generated frequency from a 24-bit phase stream
// (2*pi = 2^24). It counts phase wraps over a gate window of GATE_CYCLES samples and
// reports wraps per window, saturated to 4095. Windows run back to back once seeded.
// Optional feature: define PHASE_FREQ_METER_STEP_EN to report the last phase increment
// on o_step. Without it o_step is tied to zero and no subtractor is built.
module phase_frequency_meter #(
   parameter int unsigned GATE_CYCLES = 50_000_000,
   parameter int unsigned CNT_W       = 26
) (
   input logic                    i_clk,
   input logic                    i_arst,
   phase_frequency_meter_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_SEED  = 4'b0010,
      S_GATE  = 4'b0100,
      S_LATCH = 4'b1000
   } state_t;

   // gate_cnt value during the sample that closes a window
   localparam logic [CNT_W-1:0] GATE_PRE = CNT_W'(GATE_CYCLES - 2);
   localparam logic [12:0]      WRAP_MAX = 13'd4096;

   state_t           state, state_nxt;
   logic [23:0]      prev;
   logic [CNT_W-1:0] gate_cnt;
   logic [12:0]      wrap_cnt;
   logic [12:0]      wrap_sum;
   logic             wrap;
   logic             gate_last;
   logic             seed, count, restart, latch;
   logic [11:0]      freq_q;
   logic             freq_valid_q;
   logic             overflow_q;

   assign wrap      = (bus.i_angle < prev);
   assign wrap_sum  = (wrap_cnt == WRAP_MAX) ? WRAP_MAX : wrap_cnt + {12'd0, wrap};
   assign gate_last = (gate_cnt == GATE_PRE);

   // state register
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and datapath strobes; losing i_valid anywhere past idle abandons the window
   always_comb begin
      state_nxt = state;
      seed      = 1'b0;
      count     = 1'b0;
      restart   = 1'b0;
      latch     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.i_valid) state_nxt = S_SEED;
         end
         S_SEED: begin
            if (!bus.i_valid) begin
               state_nxt = S_IDLE;
            end else begin
               seed      = 1'b1;
               state_nxt = S_GATE;
            end
         end
         S_GATE: begin
            if (!bus.i_valid) begin
               state_nxt = S_IDLE;
            end else begin
               count = 1'b1;
               if (gate_last) begin
                  latch     = 1'b1;
                  state_nxt = S_LATCH;
               end
            end
         end
         S_LATCH: begin
            if (!bus.i_valid) begin
               state_nxt = S_IDLE;
            end else begin
               restart   = 1'b1;
               state_nxt = S_GATE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // previous sample, gate and wrap counters; the latch-cycle sample opens the next window
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         prev     <= '0;
         gate_cnt <= '0;
         wrap_cnt <= '0;
      end else if (seed) begin
         prev     <= bus.i_angle;
         gate_cnt <= '0;
         wrap_cnt <= '0;
      end else if (count) begin
         prev     <= bus.i_angle;
         gate_cnt <= gate_cnt + 1'b1;
         wrap_cnt <= wrap_sum;
      end else if (restart) begin
         prev     <= bus.i_angle;
         gate_cnt <= '0;
         wrap_cnt <= {12'd0, wrap};
      end
   end

   // result registers, loaded on the edge that takes the window's last sample so the
   // pulse and the new value appear together during the latch state
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         freq_q       <= '0;
         freq_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         freq_valid_q <= latch;
         if (latch) begin
            freq_q     <= wrap_sum[12] ? 12'hFFF : wrap_sum[11:0];
            overflow_q <= wrap_sum[12];
         end
      end
   end

   assign bus.o_frequency  = freq_q;
   assign bus.o_freq_valid = freq_valid_q;
   assign bus.o_overflow   = overflow_q;

`ifdef PHASE_FREQ_METER_STEP_EN
   // a - b as a + ~b + 1 with 4-bit groups and lookahead carries between groups
   function automatic logic [23:0] cla_sub24(input logic [23:0] a, input logic [23:0] b);
      logic [23:0] x, g, p, c;
      logic [5:0]  gg, gp, gc;
      x = ~b;
      g = a & x;
      p = a ^ x;
      for (int unsigned k = 0; k < 6; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
      end
      gc[0] = 1'b1;
      for (int unsigned k = 0; k < 5; k++) begin
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      end
      for (int unsigned k = 0; k < 6; k++) begin
         c[4*k] = gc[k];
         for (int unsigned j = 0; j < 3; j++) begin
            c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
         end
      end
      return p ^ c;
   endfunction

   logic [23:0] step_q;
   logic [23:0] diff;

   assign diff = cla_sub24(bus.i_angle, prev);

   // phase increment of each valid counted sample; holds otherwise
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         step_q <= '0;
      end else if (count || restart) begin
         step_q <= diff;
      end
   end

   assign bus.o_step = step_q;
`else
   assign bus.o_step = '0;
`endif

endmodule
